// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified memory port between instruction fetch and data access.
// Data side wins by default; fetch is forced ahead after STARVE_MAX data grants.
module mem_port_arbiter #(
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned TIMEOUT    = 15
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic        if_gnt_o,
   output logic        if_rvalid_o,
   output logic [31:0] if_rdata_o,
   output logic        if_err_o,
   input  logic        dm_req_i,
   input  logic        dm_we_i,
   input  logic [3:0]  dm_be_i,
   input  logic [31:0] dm_addr_i,
   input  logic [31:0] dm_wdata_i,
   output logic        dm_gnt_o,
   output logic        dm_rvalid_o,
   output logic [31:0] dm_rdata_o,
   output logic        dm_err_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i,
   output logic        busy_o
);

   localparam int unsigned SW = 4;
   localparam int unsigned TW = 8;

   typedef enum logic [1:0] {IDLE, IF_ACC, DM_ACC} state_t;

   state_t          r_state;
   logic [SW-1:0]   r_starve_cnt;
   logic [TW-1:0]   r_tmo_cnt;
   logic            r_mem_req, r_mem_we;
   logic [3:0]      r_mem_be;
   logic [31:0]     r_mem_addr, r_mem_wdata;
   logic            r_if_rvalid, r_if_err, r_dm_rvalid, r_dm_err;
   logic [31:0]     r_if_rdata, r_dm_rdata;

   logic            w_dm_win, w_if_win, w_acc, w_tmo, w_done;
   logic [31:0]     w_ret_data;

   // Same-cycle grant; fetch only overtakes data once the starvation bound is hit
   assign w_dm_win   = (r_state == IDLE) && dm_req_i &&
                       !(if_req_i && (r_starve_cnt == SW'(STARVE_MAX)));
   assign w_if_win   = (r_state == IDLE) && !w_dm_win && if_req_i;
   assign w_acc      = (r_state != IDLE);
   assign w_tmo      = w_acc && !mem_ack_i && (r_tmo_cnt == TW'(TIMEOUT - 1));
   assign w_done     = w_acc && (mem_ack_i || w_tmo);
   assign w_ret_data = (mem_ack_i && !r_mem_we) ? mem_rdata_i : 32'h0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state      <= IDLE;
         r_starve_cnt <= '0;
         r_tmo_cnt    <= '0;
         r_mem_req    <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_be     <= '0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_if_rvalid  <= 1'b0;
         r_if_err     <= 1'b0;
         r_if_rdata   <= '0;
         r_dm_rvalid  <= 1'b0;
         r_dm_err     <= 1'b0;
         r_dm_rdata   <= '0;
      end else begin
         r_if_rvalid <= 1'b0;
         r_if_err    <= 1'b0;
         r_dm_rvalid <= 1'b0;
         r_dm_err    <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_dm_win) begin
                  r_state     <= DM_ACC;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= dm_we_i;
                  r_mem_be    <= dm_be_i;
                  r_mem_addr  <= dm_addr_i;
                  r_mem_wdata <= dm_wdata_i;
                  r_tmo_cnt   <= '0;
                  if (!if_req_i)
                     r_starve_cnt <= '0;
                  else if (r_starve_cnt < SW'(STARVE_MAX))
                     r_starve_cnt <= r_starve_cnt + SW'(1);
               end else if (w_if_win) begin
                  r_state      <= IF_ACC;
                  r_mem_req    <= 1'b1;
                  r_mem_we     <= 1'b0;
                  r_mem_be     <= 4'hF;
                  r_mem_addr   <= if_addr_i;
                  r_mem_wdata  <= '0;
                  r_tmo_cnt    <= '0;
                  r_starve_cnt <= '0;
               end
            end
            IF_ACC, DM_ACC: begin
               if (w_done) begin
                  r_state   <= IDLE;
                  r_mem_req <= 1'b0;
                  if (r_state == IF_ACC) begin
                     r_if_rvalid <= 1'b1;
                     r_if_err    <= !mem_ack_i;
                     r_if_rdata  <= w_ret_data;
                  end else begin
                     r_dm_rvalid <= 1'b1;
                     r_dm_err    <= !mem_ack_i;
                     r_dm_rdata  <= w_ret_data;
                  end
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + TW'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign if_gnt_o    = w_if_win;
   assign dm_gnt_o    = w_dm_win;
   assign if_rvalid_o = r_if_rvalid;
   assign if_rdata_o  = r_if_rdata;
   assign if_err_o    = r_if_err;
   assign dm_rvalid_o = r_dm_rvalid;
   assign dm_rdata_o  = r_dm_rdata;
   assign dm_err_o    = r_dm_err;
   assign mem_req_o   = r_mem_req;
   assign mem_we_o    = r_mem_we;
   assign mem_be_o    = r_mem_be;
   assign mem_addr_o  = r_mem_addr;
   assign mem_wdata_o = r_mem_wdata;
   assign busy_o      = w_acc;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: memory responder plus a completion scoreboard.
module tb_mem_port_arbiter;

   logic        clk, rst_n;
   logic        if_req_i, if_gnt_o, if_rvalid_o, if_err_o;
   logic [31:0] if_addr_i, if_rdata_o;
   logic        dm_req_i, dm_we_i, dm_gnt_o, dm_rvalid_o, dm_err_o;
   logic [3:0]  dm_be_i;
   logic [31:0] dm_addr_i, dm_wdata_i, dm_rdata_o;
   logic        mem_req_o, mem_we_o, mem_ack_i;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
   logic        busy_o;

   typedef struct packed {
      logic        is_dm;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad   = 0;
   int          n_rv  = 0;
   int          ack_lat = 0;
   int          req_cyc = 0;
   logic [31:0] rd_val = 32'h0;

   mem_port_arbiter #(.STARVE_MAX(4), .TIMEOUT(15)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
      .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
      .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i),
      .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o),
      .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o), .dm_err_o(dm_err_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy_o && n < 60) begin
         tick();
         n++;
      end
      chk(tag, 32'(busy_o), 32'h0);
   endtask

   // Memory model: acks on the ack_lat-th cycle of mem_req_o (0 = never)
   always @(negedge clk) begin
      mem_ack_i = 1'b0;
      if (rst_n && mem_req_o) begin
         req_cyc++;
         if (ack_lat != 0 && req_cyc == ack_lat) begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = rd_val;
         end
      end else begin
         req_cyc = 0;
      end
   end

   // Completion checker against the scoreboard
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         chk("gnt_excl", 32'(if_gnt_o & dm_gnt_o), 32'h0);
         if (if_rvalid_o || dm_rvalid_o) begin
            n_rv++;
            total++;
            assert (sb.size() != 0) else begin
               bad++;
               $error("FAIL unexp_rvalid observed=%0d expected=0 pulses", 1);
            end
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("rv_port", 32'(dm_rvalid_o), 32'(e.is_dm));
               chk("rv_both", 32'(if_rvalid_o & dm_rvalid_o), 32'h0);
               chk("rv_data", e.is_dm ? dm_rdata_o : if_rdata_o, e.data);
               chk("rv_err", 32'(e.is_dm ? dm_err_o : if_err_o), 32'(e.err));
            end
         end else begin
            chk("err_idle", 32'({if_err_o, dm_err_o}), 32'h0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench hung");
   end

   initial begin
      logic [9:0] gseq;
      int ng, cyc, nreq, rv_snap;

      rst_n = 1'b0; if_req_i = 1'b0; if_addr_i = '0;
      dm_req_i = 1'b0; dm_we_i = 1'b0; dm_be_i = 4'hF; dm_addr_i = '0; dm_wdata_i = '0;
      mem_ack_i = 1'b0; mem_rdata_i = '0;
      tick(); tick();
      chk("rst_busy", 32'(busy_o), 32'h0);
      chk("rst_mem_req", 32'(mem_req_o), 32'h0);
      chk("rst_mem_addr", mem_addr_o, 32'h0);
      chk("rst_rvalid", 32'({if_rvalid_o, dm_rvalid_o}), 32'h0);
      chk("rst_if_rdata", if_rdata_o, 32'h0);
      rst_n = 1'b1;
      tick();

      // IF only, ack 2 cycles into the access
      rd_val = 32'h0050_0093; ack_lat = 2;
      if_req_i = 1'b1; if_addr_i = 32'h100;
      sb.push_back('{1'b0, 32'h0050_0093, 1'b0});
      #1;
      chk("if_gnt_T", 32'(if_gnt_o), 32'h1);
      chk("if_dm_gnt_T", 32'(dm_gnt_o), 32'h0);
      tick(); if_req_i = 1'b0;
      chk("if_mem_req", 32'(mem_req_o), 32'h1);
      chk("if_mem_addr", mem_addr_o, 32'h100);
      chk("if_mem_we", 32'(mem_we_o), 32'h0);
      chk("if_mem_be", 32'(mem_be_o), 32'hF);
      chk("if_busy", 32'(busy_o), 32'h1);
      tick(); tick();
      chk("if_rvalid_T3", 32'(if_rvalid_o), 32'h1);
      chk("if_rdata_T3", if_rdata_o, 32'h0050_0093);
      chk("if_busy_T3", 32'(busy_o), 32'h0);
      chk("if_mem_req_T3", 32'(mem_req_o), 32'h0);
      tick();
      chk("if_rvalid_pulse", 32'(if_rvalid_o), 32'h0);
      chk("if_rdata_hold", if_rdata_o, 32'h0050_0093);

      // Simultaneous requests: data first, fetch granted on the dm_rvalid cycle
      rd_val = 32'h1111_2222; ack_lat = 1;
      dm_req_i = 1'b1; dm_we_i = 1'b0; dm_be_i = 4'hF; dm_addr_i = 32'h2000;
      if_req_i = 1'b1; if_addr_i = 32'h104;
      sb.push_back('{1'b1, 32'h1111_2222, 1'b0});
      sb.push_back('{1'b0, 32'h1111_2222, 1'b0});
      #1;
      chk("sim_dm_gnt", 32'(dm_gnt_o), 32'h1);
      chk("sim_if_gnt", 32'(if_gnt_o), 32'h0);
      tick(); dm_req_i = 1'b0;
      chk("sim_mem_addr_dm", mem_addr_o, 32'h2000);
      chk("sim_no_gnt_acc", 32'(if_gnt_o), 32'h0);
      tick();
      chk("sim_dm_rvalid", 32'(dm_rvalid_o), 32'h1);
      chk("sim_if_gnt_late", 32'(if_gnt_o), 32'h1);
      tick(); if_req_i = 1'b0;
      chk("sim_mem_addr_if", mem_addr_o, 32'h104);
      wait_idle("sim_idle");

      // Store: completion carries zero data
      rd_val = 32'h5555_5555; ack_lat = 3;
      dm_req_i = 1'b1; dm_we_i = 1'b1; dm_be_i = 4'b0011;
      dm_addr_i = 32'h3000; dm_wdata_i = 32'hDEAD_BEEF;
      sb.push_back('{1'b1, 32'h0, 1'b0});
      #1;
      chk("st_gnt", 32'(dm_gnt_o), 32'h1);
      tick(); dm_req_i = 1'b0; dm_we_i = 1'b0;
      chk("st_mem_we", 32'(mem_we_o), 32'h1);
      chk("st_mem_be", 32'(mem_be_o), 32'h3);
      chk("st_mem_wdata", mem_wdata_o, 32'hDEAD_BEEF);
      chk("st_mem_addr", mem_addr_o, 32'h3000);
      wait_idle("st_idle");
      chk("st_rvalid", 32'(dm_rvalid_o), 32'h1);
      chk("st_rdata", dm_rdata_o, 32'h0);

      // Starvation: both held, expect DDDDI DDDDI
      tick();
      rd_val = 32'h77; ack_lat = 1;
      dm_req_i = 1'b1; dm_we_i = 1'b0; dm_be_i = 4'hF; dm_addr_i = 32'h4000;
      if_req_i = 1'b1; if_addr_i = 32'h200;
      for (int k = 0; k < 10; k++)
         sb.push_back('{(k != 4 && k != 9), 32'h77, 1'b0});
      #1;
      gseq = '0; ng = 0; cyc = 0;
      while (ng < 10 && cyc < 100) begin
         if (dm_gnt_o || if_gnt_o) begin
            gseq[ng] = if_gnt_o;
            ng++;
            if (ng == 10) break;
         end
         tick();
         cyc++;
      end
      chk("starve_ngnt", 32'(ng), 32'd10);
      chk("starve_seq", 32'(gseq), 32'(10'b10_0001_0000));
      tick(); dm_req_i = 1'b0; if_req_i = 1'b0;
      wait_idle("starve_idle");

      // Timeout on a load with no ack
      tick();
      ack_lat = 0;
      dm_req_i = 1'b1; dm_addr_i = 32'h5000;
      sb.push_back('{1'b1, 32'h0, 1'b1});
      #1;
      chk("tmo_gnt", 32'(dm_gnt_o), 32'h1);
      tick(); dm_req_i = 1'b0;
      nreq = 0;
      while (mem_req_o && nreq < 40) begin
         nreq++;
         tick();
      end
      chk("tmo_req_cycles", 32'(nreq), 32'd15);
      chk("tmo_rvalid", 32'(dm_rvalid_o), 32'h1);
      chk("tmo_err", 32'(dm_err_o), 32'h1);
      chk("tmo_rdata", dm_rdata_o, 32'h0);
      tick();

      // Ack on the final allowed cycle still completes normally
      rd_val = 32'h1234_5678; ack_lat = 15;
      dm_req_i = 1'b1; dm_addr_i = 32'h5004;
      sb.push_back('{1'b1, 32'h1234_5678, 1'b0});
      #1;
      tick(); dm_req_i = 1'b0;
      nreq = 0;
      while (mem_req_o && nreq < 40) begin
         nreq++;
         tick();
      end
      chk("tmo_edge_cycles", 32'(nreq), 32'd15);
      chk("tmo_edge_err", 32'(dm_err_o), 32'h0);
      chk("tmo_edge_rdata", dm_rdata_o, 32'h1234_5678);
      tick();

      // Reset in the middle of a data access abandons it
      ack_lat = 0;
      dm_req_i = 1'b1; dm_addr_i = 32'h6000;
      #1;
      tick(); dm_req_i = 1'b0;
      tick(); tick();
      chk("mrst_busy_pre", 32'(busy_o), 32'h1);
      rv_snap = n_rv;
      rst_n = 1'b0;
      #1;
      chk("mrst_mem_req", 32'(mem_req_o), 32'h0);
      chk("mrst_busy", 32'(busy_o), 32'h0);
      tick();
      rst_n = 1'b1;
      tick(); tick(); tick();
      chk("mrst_no_rvalid", 32'(n_rv), 32'(rv_snap));

      rd_val = 32'hCAFE_F00D; ack_lat = 2;
      if_req_i = 1'b1; if_addr_i = 32'h700;
      sb.push_back('{1'b0, 32'hCAFE_F00D, 1'b0});
      #1;
      chk("mrst_if_gnt", 32'(if_gnt_o), 32'h1);
      tick(); if_req_i = 1'b0;
      wait_idle("mrst_idle");
      chk("mrst_if_rvalid", 32'(if_rvalid_o), 32'h1);
      chk("mrst_if_rdata", if_rdata_o, 32'hCAFE_F00D);
      tick(); tick();
      chk("sb_empty", 32'(sb.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between instruction fetch (IF) and the MEM-stage data access (DM).
- Grants one access at a time and sequences the external memory handshake.
- Returns read data or completion to the owning requester, with a timeout error.
- IF/MEM pipeline stages stall on missing grant or rvalid; data side has priority, with a starvation bound for fetch.

Parameters:
STARVE_MAX, 4, max consecutive DM grants issued while if_req_i is pending before IF is forced ahead (1..15)
TIMEOUT, 15, cycles an access may wait for mem_ack_i before it is aborted with error (2..255)

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  asynchronous active-low reset
if_req_i  input  1  fetch request; held with if_addr_i until if_gnt_o
if_addr_i  input  32  fetch address
if_gnt_o  output  1  fetch request accepted this cycle
if_rvalid_o  output  1  one-cycle pulse, if_rdata_o/if_err_o valid
if_rdata_o  output  32  fetched instruction
if_err_o  output  1  fetch timed out
dm_req_i  input  1  data request; held with attributes until dm_gnt_o
dm_we_i  input  1  1 = store, 0 = load
dm_be_i  input  4  byte enables
dm_addr_i  input  32  data address
dm_wdata_i  input  32  store data
dm_gnt_o  output  1  data request accepted this cycle
dm_rvalid_o  output  1  one-cycle completion pulse (loads and stores)
dm_rdata_o  output  32  load data; 0 for stores
dm_err_o  output  1  data access timed out
mem_req_o  output  1  memory request, held until ack or timeout
mem_we_o  output  1  memory write enable
mem_be_o  output  4  memory byte enables
mem_addr_o  output  32  memory address
mem_wdata_o  output  32  memory write data
mem_ack_i  input  1  memory done; mem_rdata_i valid same cycle
mem_rdata_i  input  32  memory read data
busy_o  output  1  state != IDLE

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs, starve_cnt and tmo_cnt 0. Reset mid-access abandons it: no rvalid, mem_req_o drops immediately.
- States: IDLE, IF_ACC, DM_ACC.
- IDLE grant, combinational, same cycle as request:
  - dm_req_i && !(if_req_i && starve_cnt==STARVE_MAX) -> dm_gnt_o=1, next DM_ACC.
  - else if_req_i -> if_gnt_o=1, next IF_ACC.
  - Never both gnt in one cycle; no grant outside IDLE.
- On grant, request fields are registered into mem_*_o. IF accesses drive mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0.
- mem_req_o=1 throughout IF_ACC/DM_ACC; mem_* fields stable until exit.
- tmo_cnt clears on grant and increments each ACC cycle without mem_ack_i.
- mem_ack_i in ACC: capture mem_rdata_i (forced to 0 for stores). Next cycle: owner's rvalid pulses with err=0, state IDLE, mem_req_o=0.
- tmo_cnt reaching TIMEOUT-1 with no ack aborts the access. Next cycle: owner's rvalid=1, err=1, rdata=0, state IDLE. Ack in the same cycle as the timeout edge wins (normal completion).
- mem_ack_i outside ACC is ignored.
- Latency: grant at T, mem_req_o from T+1, ack at T+k (k>=1), rvalid at T+k+1. A new grant may occur in cycle T+k+1 (back-to-back), one idle memory cycle between accesses.
- starve_cnt updates at each DM grant: +1 if if_req_i is high (saturates at STARVE_MAX), else cleared to 0. It is cleared on every IF grant.
- rdata outputs hold their last value between rvalid pulses; err outputs are 0 except with rvalid.

Test Plan:
- IF only: if_req_i with addr 0x100, mem acks 2 cycles after mem_req_o with 0x00500093 -> if_gnt_o at T, mem_addr_o=0x100 at T+1, if_rvalid_o/if_rdata_o=0x00500093 at T+3, busy_o low at T+3.
- Simultaneous requests, starve_cnt=0: dm load 0x2000 and if 0x104 -> dm_gnt_o first; if_gnt_o in the cycle dm_rvalid_o pulses.
- Store: dm_we_i=1, be=4'b0011, wdata 0xDEADBEEF -> mem_we_o=1, mem_be_o=0011, mem_wdata_o=0xDEADBEEF; dm_rvalid_o with dm_rdata_o=0.
- Starvation: dm_req_i and if_req_i held high, ack 1 cycle -> exactly 4 DM grants, then 1 IF grant, then DM resumes.
- Timeout: no ack for a DM load -> mem_req_o high 15 cycles then low; dm_rvalid_o=1, dm_err_o=1, dm_rdata_o=0. Ack on the 15th cycle -> err=0, data returned.
- Reset mid-access: rst_ni low during DM_ACC -> mem_req_o, busy_o 0 immediately; no dm_rvalid_o after release; next request is granted normally.
